// File: rtl/reg_file_pkg.sv
// Shared defaults and address helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int REG_W  = 8;
  localparam int REG_D  = 3;
  localparam int REG_NR = 2;

  // An address is writable/reservable unless it is the hardwired zero register.
  function automatic logic idx_ok(input int addr, input logic zero_r0);
    return !(zero_r0 && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-bit scoreboard: tracks registers reserved by multi-cycle producers,
// grants reserves and reports per-read-port pending status.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int D       = REG_D,
  parameter int ZERO_R0 = 1,
  parameter int NR      = REG_NR
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic [D-1:0]  wr_addr,
  input  logic          rsv_en,
  input  logic [D-1:0]  rsv_addr,
  output logic          rsv_ack,
  input  logic [NR*D-1:0] rd_addr,
  output logic [NR-1:0] rd_pending,
  output logic [D:0]    pending_count
);

  localparam int   N = 2 ** D;
  localparam logic Z = (ZERO_R0 != 0);

  logic [N-1:0] pending_reg, pending_next;
  logic [D:0]   count_reg, count_next;
  logic         wr_ok, rsv_ok, rsv_set, cnt_inc, cnt_dec;

  always_comb begin
    wr_ok   = wr_en && idx_ok(int'(wr_addr), Z);
    rsv_ok  = idx_ok(int'(rsv_addr), Z);
    // A same-cycle write to the requested address frees it, so back-to-back loads chain.
    rsv_ack = rsv_en && (!rsv_ok || !pending_reg[rsv_addr] ||
                         (wr_en && (wr_addr == rsv_addr)));
    rsv_set = rsv_ack && rsv_ok;
    cnt_inc = rsv_set && !pending_reg[rsv_addr];
    cnt_dec = wr_ok && pending_reg[wr_addr] && !(rsv_set && (rsv_addr == wr_addr));

    pending_next = pending_reg;
    if (wr_ok)
      pending_next[wr_addr] = 1'b0;
    if (rsv_set)
      pending_next[rsv_addr] = 1'b1;

    count_next = count_reg + {{D{1'b0}}, cnt_inc} - {{D{1'b0}}, cnt_dec};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pending_reg <= '0;
      count_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_lookup
    assign rd_pending[gi] = pending_reg[rd_addr[gi*D +: D]];
  end

  assign pending_count = count_reg;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with N combinational read ports, write bypass,
// optional hardwired-zero R0 and a pending scoreboard for multi-cycle producers.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int W       = REG_W,
  parameter int D       = REG_D,
  parameter int NR      = REG_NR,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Reg_write_en,
  input  logic [D-1:0]    Reg_write_address,
  input  logic [W-1:0]    Reg_write_data,
  input  logic            Reserve_en,
  input  logic [D-1:0]    Reserve_address,
  output logic            Reserve_ack,
  input  logic [NR*D-1:0] Reg_read_address,
  output logic [NR*W-1:0] Source_data,
  output logic [NR-1:0]   Source_ready,
  output logic [D:0]      Pending_count
);

  localparam int   N = 2 ** D;
  localparam logic Z = (ZERO_R0 != 0);

  logic [W-1:0]  regs_reg [N];
  logic [NR-1:0] rd_pending;

  reg_scoreboard #(
    .D      (D),
    .ZERO_R0(ZERO_R0),
    .NR     (NR)
  ) u_scoreboard (
    .CLK          (CLK),
    .Reset        (Reset),
    .wr_en        (Reg_write_en),
    .wr_addr      (Reg_write_address),
    .rsv_en       (Reserve_en),
    .rsv_addr     (Reserve_address),
    .rsv_ack      (Reserve_ack),
    .rd_addr      (Reg_read_address),
    .rd_pending   (rd_pending),
    .pending_count(Pending_count)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < N; i++)
        regs_reg[i] <= '0;
    end else if (Reg_write_en && idx_ok(int'(Reg_write_address), Z)) begin
      regs_reg[Reg_write_address] <= Reg_write_data;
    end
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    logic [D-1:0] addr;
    logic [W-1:0] data;
    logic         rdy;

    assign addr = Reg_read_address[gi*D +: D];

    // Zero register beats bypass, bypass beats stored state.
    always_comb begin
      data = regs_reg[addr];
      rdy  = !rd_pending[gi];
      if (!idx_ok(int'(addr), Z)) begin
        data = '0;
        rdy  = 1'b1;
      end else if ((BYPASS != 0) && Reg_write_en && (Reg_write_address == addr)) begin
        data = Reg_write_data;
        rdy  = 1'b1;
      end
    end

    assign Source_data[gi*W +: W] = data;
    assign Source_ready[gi]       = rdy;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed plus randomized bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [2:0]  wa, ra;
  logic [7:0]  wd;
  logic [5:0]  raddr;
  logic [15:0] sdata;
  logic [1:0]  sready;
  logic        ack;
  logic [3:0]  pcount;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_regs [8];
  bit         m_pend [8];
  bit         m_ack;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .CLK              (clk),
    .Reset            (rst),
    .Reg_write_en     (we),
    .Reg_write_address(wa),
    .Reg_write_data   (wd),
    .Reserve_en       (re),
    .Reserve_address  (ra),
    .Reserve_ack      (ack),
    .Reg_read_address (raddr),
    .Source_data      (sdata),
    .Source_ready     (sready),
    .Pending_count    (pcount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic bit m_ack_calc();
    return re && (ra == 0 || !m_pend[ra] || (we && wa == ra));
  endfunction

  // Drive one cycle's inputs after the falling edge and check the combinational view.
  task automatic set_inputs(input logic r, input logic w, input logic [2:0] a_w,
                            input logic [7:0] d_w, input logic v, input logic [2:0] a_r,
                            input logic [2:0] a0, input logic [2:0] a1);
    logic [2:0] a;
    logic [7:0] ed;
    logic       er;
    @(negedge clk);
    rst = r; we = w; wa = a_w; wd = d_w; re = v; ra = a_r;
    raddr = {a1, a0};
    #1;
    m_ack = m_ack_calc();
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? a0 : a1;
      if (a == 0) begin
        ed = 8'h00; er = 1'b1;
      end else if (we && wa == a) begin
        ed = wd; er = 1'b1;
      end else begin
        ed = m_regs[a]; er = !m_pend[a];
      end
      check($sformatf("p%0d_data a=%0d", i, a), 32'(sdata[i*8 +: 8]), 32'(ed));
      check($sformatf("p%0d_ready a=%0d", i, a), 32'(sready[i]), 32'(er));
    end
    if (!rst) check("reserve_ack", 32'(ack), 32'(m_ack));
    check("pending_count", 32'(pcount), 32'(m_count()));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = 8'h00; m_pend[i] = 0;
      end
    end else begin
      if (we && wa != 0) begin
        m_regs[wa] = wd; m_pend[wa] = 0;
      end
      if (m_ack && ra != 0) m_pend[ra] = 1;
    end
  endtask

  initial begin
    logic       h_re;
    logic [2:0] h_ra;
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 8'h00; m_pend[i] = 0;
    end
    rst = 1; we = 0; wa = 0; wd = 0; re = 0; ra = 0; raddr = 0;

    // Reset, then idle reads
    set_inputs(1, 0, 0, 8'h00, 0, 0, 1, 7); advance();
    set_inputs(1, 0, 0, 8'h00, 0, 0, 1, 7); advance();
    set_inputs(0, 0, 0, 8'h00, 0, 0, 1, 7);
    check("init_data", 32'(sdata), 32'h0000);
    check("init_ready", 32'(sready), 32'h3);
    advance();

    // Bypass write to R3
    set_inputs(0, 1, 3, 8'hA5, 0, 0, 3, 1);
    check("bypass_r3", 32'(sdata[7:0]), 32'hA5);
    advance();
    set_inputs(0, 0, 0, 8'h00, 0, 0, 3, 1);
    check("stored_r3", 32'(sdata[7:0]), 32'hA5);
    advance();

    // Reserve R4, re-reserve refused, write releases it
    set_inputs(0, 0, 0, 8'h00, 1, 4, 0, 4);
    check("rsv_r4_ack", 32'(ack), 32'h1);
    advance();
    set_inputs(0, 0, 0, 8'h00, 0, 0, 0, 4);
    check("r4_not_ready", 32'(sready[1]), 32'h0);
    check("count_one", 32'(pcount), 32'h1);
    advance();
    set_inputs(0, 0, 0, 8'h00, 1, 4, 0, 4);
    check("rsv_r4_nack", 32'(ack), 32'h0);
    advance();
    set_inputs(0, 1, 4, 8'h3C, 0, 0, 0, 4);
    check("r4_write_data", 32'(sdata[15:8]), 32'h3C);
    check("r4_write_ready", 32'(sready[1]), 32'h1);
    advance();
    set_inputs(0, 0, 0, 8'h00, 0, 0, 0, 4);
    check("count_zero", 32'(pcount), 32'h0);
    advance();

    // Back-to-back load into R5
    set_inputs(0, 0, 0, 8'h00, 1, 5, 5, 0); advance();
    set_inputs(0, 1, 5, 8'h11, 1, 5, 5, 0);
    check("r5_chain_ack", 32'(ack), 32'h1);
    advance();
    set_inputs(0, 0, 0, 8'h00, 0, 0, 5, 0);
    check("r5_data", 32'(sdata[7:0]), 32'h11);
    check("r5_ready", 32'(sready[0]), 32'h0);
    check("r5_count", 32'(pcount), 32'h1);
    advance();
    set_inputs(0, 1, 5, 8'h22, 0, 0, 5, 0); advance();

    // Zero register ignores write and reserve
    set_inputs(0, 1, 0, 8'hFF, 1, 0, 0, 0);
    check("r0_ack", 32'(ack), 32'h1);
    check("r0_data", 32'(sdata[7:0]), 32'h00);
    advance();
    set_inputs(0, 0, 0, 8'h00, 0, 0, 0, 0);
    check("r0_count", 32'(pcount), 32'h0);
    advance();

    // Reset dominates a same-cycle write
    set_inputs(0, 0, 0, 8'h00, 1, 2, 2, 6); advance();
    set_inputs(0, 0, 0, 8'h00, 1, 6, 2, 6); advance();
    set_inputs(1, 1, 2, 8'h77, 0, 0, 2, 6); advance();
    set_inputs(0, 0, 0, 8'h00, 0, 0, 2, 6);
    check("rst_r2", 32'(sdata[7:0]), 32'h00);
    check("rst_ready", 32'(sready), 32'h3);
    check("rst_count", 32'(pcount), 32'h0);
    advance();

    // Randomized traffic; an unacked reserve is held until granted
    h_re = 0; h_ra = 0;
    for (int n = 0; n < 400; n++) begin
      logic       r_rst, r_we, r_re;
      logic [2:0] r_ra;
      r_rst = ($urandom_range(0, 39) == 0);
      r_we  = ($urandom_range(0, 2) != 0);
      if (h_re) begin
        r_re = 1; r_ra = h_ra;
      end else begin
        r_re = ($urandom_range(0, 1) == 1); r_ra = 3'($urandom_range(0, 7));
      end
      set_inputs(r_rst, r_we, 3'($urandom_range(0, 7)), 8'($urandom),
                 r_re, r_ra, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      h_re = re && !m_ack && !rst;
      h_ra = ra;
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
